// File: rtl/cnn_pkg.sv
// Shared constants, types and post-processing helpers for the conv/pool engine.
package cnn_pkg;

  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned BUF_WIDTH    = 26;
  localparam int unsigned MAP_SIZE     = 32;
  localparam int unsigned PADDING      = 1;
  localparam int unsigned KERNEL_SIZE  = 3;
  localparam int unsigned STRIDE       = 2;
  localparam int unsigned POOLING_SIZE = 2;
  localparam int unsigned NUM_CH       = 64;

  localparam int unsigned PAD_SIZE     = MAP_SIZE + 2 * PADDING;
  localparam int unsigned OUT_SIZE     = MAP_SIZE / POOLING_SIZE;
  localparam int unsigned ROWS_PER_WORD = 4;
  localparam int unsigned IFM_WORDS    = MAP_SIZE / ROWS_PER_WORD;

  localparam int unsigned IFM_AW       = 9;
  localparam int unsigned IFM_DW       = 2048;
  localparam int unsigned KER_AW       = 6;
  localparam int unsigned KER_DW       = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;
  localparam int unsigned BIAS_W       = 16;
  localparam int unsigned OFM_W        = OUT_SIZE * OUT_SIZE * DATA_WIDTH;
  localparam int unsigned CH_W         = 6;
  localparam int unsigned CNT_W        = 6;

  localparam int unsigned Q_SHIFT      = 9;
  localparam int unsigned Q_W          = BUF_WIDTH - Q_SHIFT;
  localparam int unsigned Q_MAX        = 127;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_LDK  = 3'd2,
    ST_LDI  = 3'd3,
    ST_MAC  = 3'd4,
    ST_POOL = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  typedef logic [DATA_WIDTH-1:0]                                  pix_t;
  typedef logic signed [BUF_WIDTH-1:0]                            acc_t;
  typedef logic [KERNEL_SIZE-1:0][PAD_SIZE-1:0][DATA_WIDTH-1:0]   pad_rows_t;
  typedef logic [KERNEL_SIZE*KERNEL_SIZE-1:0][DATA_WIDTH-1:0]     kernel_t;
  typedef logic [MAP_SIZE-1:0][BUF_WIDTH-1:0]                     row_sum_t;
  typedef logic [OUT_SIZE-1:0][DATA_WIDTH-1:0]                    ofm_row_t;
  typedef logic [OUT_SIZE-1:0][OUT_SIZE-1:0][DATA_WIDTH-1:0]      ofm_t;

  function automatic acc_t max2(input acc_t a, input acc_t b);
    return (a > b) ? a : b;
  endfunction

  // ReLU, then divide by 512 with round-half-up, saturating at +127.
  function automatic pix_t quantize(input acc_t m);
    acc_t           pos;
    logic [Q_W-1:0] q;
    pos = (m < 0) ? '0 : m;
    q   = pos[BUF_WIDTH-1:Q_SHIFT];
    if (q >= Q_W'(Q_MAX)) begin
      return pix_t'(Q_MAX);
    end
    return pix_t'(q) + pix_t'(pos[Q_SHIFT-1]);
  endfunction

endpackage

// File: rtl/cnn_row_mac.sv
// One output row of 3x3 convolution: 32 lanes, each summing 9 signed 8x8 products.
module cnn_row_mac
  import cnn_pkg::*;
(
  input  pad_rows_t rows_i,
  input  kernel_t   kernel_i,
  output row_sum_t  sums_o
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  acc_t                           lane;

  always_comb begin
    sums_o = '0;
    prod   = '0;
    lane   = '0;
    for (int x = 0; x < MAP_SIZE; x++) begin
      lane = '0;
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int s = 0; s < KERNEL_SIZE; s++) begin
          prod = $signed(rows_i[r][x+s]) * $signed(kernel_i[r*KERNEL_SIZE+s]);
          lane = lane + acc_t'(prod);
        end
      end
      sums_o[x] = lane;
    end
  end

endmodule

// File: rtl/cnn_conv_pool.sv
// Single-output-channel conv layer: 64-channel 3x3 conv + bias, 2x2 max-pool, ReLU, int8 quantize.
module cnn_conv_pool
  import cnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              idle,
  output logic              finish,
  output logic              ifm_rd,
  output logic [IFM_AW-1:0] ifm_addr,
  input  logic [IFM_DW-1:0] ifm_readdata,
  output logic              kernel_rd,
  output logic [KER_AW-1:0] kernel_addr,
  input  logic [KER_DW-1:0] kernel_readdata,
  input  logic [BIAS_W-1:0] bias,
  output logic [OFM_W-1:0]  ofm
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                idle_q, idle_d;
  logic                finish_q, finish_d;
  logic                ifm_rd_q, ifm_rd_d;
  logic [IFM_AW-1:0]   ifm_addr_q, ifm_addr_d;
  logic                kernel_rd_q, kernel_rd_d;
  logic [KER_AW-1:0]   kernel_addr_q, kernel_addr_d;

  pix_t                pix_q [MAP_SIZE][MAP_SIZE];
  acc_t                acc_q [MAP_SIZE][MAP_SIZE];
  kernel_t             kernel_q;
  ofm_t                stage_q;
  ofm_t                ofm_q;

  pad_rows_t           pad_rows;
  row_sum_t            row_sum;
  ofm_row_t            pool_row;
  logic [CNT_W-1:0]    src_row;
  logic [2:0]          word_idx;
  logic [4:0]          mac_row;
  logic [4:0]          pool_top;
  logic [4:0]          pool_bot;
  acc_t                bias_ext;
  logic                unused_ifm_hi;

  // Only the low four 256-bit rows of each IFM word carry pixels.
  assign unused_ifm_hi = ^ifm_readdata[IFM_DW-1:ROWS_PER_WORD*MAP_SIZE*DATA_WIDTH];

  assign bias_ext = acc_t'($signed(bias));
  assign word_idx = 3'(cnt_q - CNT_W'(1));
  assign mac_row  = cnt_q[4:0];
  assign pool_top = {cnt_q[3:0], 1'b0};
  assign pool_bot = {cnt_q[3:0], 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      ch_q          <= '0;
      idle_q        <= 1'b1;
      finish_q      <= 1'b0;
      ifm_rd_q      <= 1'b0;
      ifm_addr_q    <= '0;
      kernel_rd_q   <= 1'b0;
      kernel_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ch_q          <= ch_d;
      idle_q        <= idle_d;
      finish_q      <= finish_d;
      ifm_rd_q      <= ifm_rd_d;
      ifm_addr_q    <= ifm_addr_d;
      kernel_rd_q   <= kernel_rd_d;
      kernel_addr_q <= kernel_addr_d;
    end
  end

  // Sequencer: read strobes and addresses are set up one state ahead so they leave flops.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ch_d          = ch_q;
    idle_d        = idle_q;
    finish_d      = finish_q;
    ifm_rd_d      = ifm_rd_q;
    ifm_addr_d    = ifm_addr_q;
    kernel_rd_d   = kernel_rd_q;
    kernel_addr_d = kernel_addr_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_INIT;
          idle_d   = 1'b0;
          finish_d = 1'b0;
        end
      end
      ST_INIT: begin
        state_d       = ST_LDK;
        ch_d          = '0;
        kernel_rd_d   = 1'b1;
        kernel_addr_d = '0;
      end
      ST_LDK: begin
        state_d     = ST_LDI;
        cnt_d       = '0;
        kernel_rd_d = 1'b0;
        ifm_rd_d    = 1'b1;
        ifm_addr_d  = {ch_q, 3'b000};
      end
      ST_LDI: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q < CNT_W'(IFM_WORDS - 1)) begin
          ifm_addr_d = ifm_addr_q + IFM_AW'(1);
        end else begin
          ifm_rd_d = 1'b0;
        end
        if (cnt_q == CNT_W'(IFM_WORDS)) begin
          state_d = ST_MAC;
          cnt_d   = '0;
        end
      end
      ST_MAC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MAP_SIZE - 1)) begin
          cnt_d = '0;
          if (ch_q == CH_W'(NUM_CH - 1)) begin
            state_d = ST_POOL;
          end else begin
            state_d       = ST_LDK;
            ch_d          = ch_q + CH_W'(1);
            kernel_rd_d   = 1'b1;
            kernel_addr_d = KER_AW'(ch_q + CH_W'(1));
          end
        end
      end
      ST_POOL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(OUT_SIZE - 1)) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          finish_d = 1'b1;
          idle_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Zero border is implied: rows outside the map and the two edge columns read as 0.
  always_comb begin
    pad_rows = '0;
    src_row  = '0;
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      src_row = cnt_q + CNT_W'(r) - CNT_W'(PADDING);
      if (src_row < CNT_W'(MAP_SIZE)) begin
        for (int p = 0; p < MAP_SIZE; p++) begin
          pad_rows[r][p+PADDING] = pix_q[src_row[4:0]][p];
        end
      end
    end
  end

  cnn_row_mac u_row_mac (
    .rows_i   (pad_rows),
    .kernel_i (kernel_q),
    .sums_o   (row_sum)
  );

  always_comb begin
    pool_row = '0;
    for (int j = 0; j < OUT_SIZE; j++) begin
      pool_row[j] = quantize(max2(max2(acc_q[pool_top][2*j], acc_q[pool_top][2*j+1]),
                                  max2(acc_q[pool_bot][2*j], acc_q[pool_bot][2*j+1])));
    end
  end

  // Datapath storage; every entry is written before it is read within a run.
  always_ff @(posedge clk) begin
    case (state_q)
      ST_INIT: begin
        for (int y = 0; y < MAP_SIZE; y++) begin
          for (int x = 0; x < MAP_SIZE; x++) begin
            acc_q[y][x] <= bias_ext;
          end
        end
      end
      ST_LDI: begin
        if (cnt_q == '0) begin
          kernel_q <= kernel_readdata;
        end else begin
          for (int r = 0; r < ROWS_PER_WORD; r++) begin
            for (int j = 0; j < MAP_SIZE; j++) begin
              pix_q[{word_idx, 2'(r)}][j] <= ifm_readdata[(r*MAP_SIZE+j)*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
      ST_MAC: begin
        for (int x = 0; x < MAP_SIZE; x++) begin
          acc_q[mac_row][x] <= acc_q[mac_row][x] + acc_t'(row_sum[x]);
        end
      end
      ST_POOL: stage_q[cnt_q[3:0]] <= pool_row;
      default: ;
    endcase
  end

  // Result bus changes only once, as the last pooled row is produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      ofm_q <= '0;
    end else if (state_q == ST_POOL && cnt_q == CNT_W'(OUT_SIZE - 1)) begin
      ofm_q <= {pool_row, stage_q[OUT_SIZE-2:0]};
    end
  end

  assign idle        = idle_q;
  assign finish      = finish_q;
  assign ifm_rd      = ifm_rd_q;
  assign ifm_addr    = ifm_addr_q;
  assign kernel_rd   = kernel_rd_q;
  assign kernel_addr = kernel_addr_q;
  assign ofm         = ofm_q;

endmodule

// File: tb/tb_cnn_conv_pool.sv
// Directed and model-checked bench for cnn_conv_pool with 1-cycle-latency IFM/kernel memories.
module tb_cnn_conv_pool;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          idle;
  logic          finish;
  logic          ifm_rd;
  logic [8:0]    ifm_addr;
  logic [2047:0] ifm_readdata;
  logic          kernel_rd;
  logic [5:0]    kernel_addr;
  logic [71:0]   kernel_readdata;
  logic [15:0]   bias;
  logic [2047:0] ofm;

  logic [2047:0] ifm_mem [512];
  logic [71:0]   ker_mem [64];

  int pix [64][32][32];
  int ker [64][9];
  int exp_ofm [16][16];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (ifm_rd)    ifm_readdata    <= ifm_mem[ifm_addr];
    if (kernel_rd) kernel_readdata <= ker_mem[kernel_addr];
  end

  cnn_conv_pool dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .idle            (idle),
    .finish          (finish),
    .ifm_rd          (ifm_rd),
    .ifm_addr        (ifm_addr),
    .ifm_readdata    (ifm_readdata),
    .kernel_rd       (kernel_rd),
    .kernel_addr     (kernel_addr),
    .kernel_readdata (kernel_readdata),
    .bias            (bias),
    .ofm             (ofm)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_mems();
    logic [2047:0] wd;
    logic [71:0]   kd;
    for (int c = 0; c < 64; c++) begin
      for (int w = 0; w < 8; w++) begin
        wd = '0;
        for (int r = 0; r < 4; r++)
          for (int j = 0; j < 32; j++)
            wd[(r*32+j)*8 +: 8] = 8'(pix[c][w*4+r][j]);
        ifm_mem[c*8+w] = wd;
      end
      kd = '0;
      for (int i = 0; i < 9; i++) kd[i*8 +: 8] = 8'(ker[c][i]);
      ker_mem[c] = kd;
    end
  endtask

  task automatic fill_const(input int pv, input int kv);
    for (int c = 0; c < 64; c++) begin
      for (int y = 0; y < 32; y++)
        for (int x = 0; x < 32; x++) pix[c][y][x] = pv;
      for (int i = 0; i < 9; i++) ker[c][i] = kv;
    end
  endtask

  task automatic fill_random(input int kmax);
    for (int c = 0; c < 64; c++) begin
      for (int y = 0; y < 32; y++)
        for (int x = 0; x < 32; x++) pix[c][y][x] = int'($urandom_range(0, 252)) - 126;
      for (int i = 0; i < 9; i++) ker[c][i] = int'($urandom_range(0, 2*kmax)) - kmax;
    end
  endtask

  task automatic fill_exp(input int v);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) exp_ofm[i][j] = v;
  endtask

  // Reference: padded conv + bias, 2x2 max, clamp at 0, divide by 512 rounding half up, cap 127.
  task automatic run_model(input int b);
    int acc [32][32];
    int py, px, m, q;
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 32; x++) begin
        acc[y][x] = b;
        for (int c = 0; c < 64; c++)
          for (int r = 0; r < 3; r++)
            for (int s = 0; s < 3; s++) begin
              py = y + r - 1;
              px = x + s - 1;
              if (py >= 0 && py < 32 && px >= 0 && px < 32)
                acc[y][x] += ker[c][r*3+s] * pix[c][py][px];
            end
      end
    end
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        m = acc[2*i][2*j];
        if (acc[2*i][2*j+1]   > m) m = acc[2*i][2*j+1];
        if (acc[2*i+1][2*j]   > m) m = acc[2*i+1][2*j];
        if (acc[2*i+1][2*j+1] > m) m = acc[2*i+1][2*j+1];
        if (m < 0) m = 0;
        q = m / 512;
        exp_ofm[i][j] = (q >= 127) ? 127 : q + (((m % 512) >= 256) ? 1 : 0);
      end
    end
  endtask

  function automatic logic [2047:0] pack_exp();
    logic [2047:0] v;
    v = '0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) v[(16*i+j)*8 +: 8] = 8'(exp_ofm[i][j]);
    return v;
  endfunction

  task automatic check_ofm(input string name);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        check($sformatf("%s_ofm_%0d_%0d", name, i, j), 32'(ofm[(16*i+j)*8 +: 8]), exp_ofm[i][j]);
  endtask

  task automatic do_run(input string name, input int b, input int busy_pulses,
                        input logic chk_hold, input logic [2047:0] hold_vec);
    int t0;
    int n;
    bias = 16'(b);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t0 = cyc;
    check($sformatf("%s_busy_idle", name), 32'(idle), 0);
    check($sformatf("%s_busy_finish", name), 32'(finish), 0);
    if (chk_hold) begin
      repeat (100) @(negedge clk);
      check($sformatf("%s_ofm_held", name), 32'(ofm == hold_vec), 1);
    end
    for (int k = 0; k < busy_pulses; k++) begin
      repeat (200) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    n = 0;
    while (!finish && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_finish", name), 32'(finish), 1);
    check($sformatf("%s_idle", name), 32'(idle), 1);
    check($sformatf("%s_latency_ok", name), 32'((cyc - t0) <= 2800), 1);
    check_ofm(name);
  endtask

  initial begin
    logic [2047:0] prev;
    int b;
    rst   = 1'b1;
    start = 1'b0;
    bias  = '0;
    ifm_readdata    = '0;
    kernel_readdata = '0;
    fill_const(0, 0);
    load_mems();
    repeat (3) @(negedge clk);
    check("rst_idle", 32'(idle), 1);
    check("rst_finish", 32'(finish), 0);
    check("rst_ifm_rd", 32'(ifm_rd), 0);
    check("rst_kernel_rd", 32'(kernel_rd), 0);
    check("rst_ifm_addr", 32'(ifm_addr), 0);
    check("rst_kernel_addr", 32'(kernel_addr), 0);
    check("rst_ofm_zero", 32'(ofm == '0), 1);
    rst = 1'b0;

    fill_exp(2);
    do_run("bias_pos", 1000, 0, 1'b0, '0);

    fill_exp(0);
    do_run("relu", -5000, 0, 1'b0, '0);

    fill_const(126, 126);
    load_mems();
    fill_exp(127);
    do_run("sat", 0, 0, 1'b0, '0);

    fill_const(0, 0);
    pix[0][0][0] = 100;
    ker[0][4]    = 64;
    load_mems();
    fill_exp(0);
    exp_ofm[0][0] = 13;
    do_run("single", 0, 0, 1'b0, '0);

    fill_random(126);
    load_mems();
    b = int'($urandom_range(0, 65535)) - 32768;
    run_model(b);
    do_run("rand1", b, 0, 1'b0, '0);

    prev = pack_exp();
    fill_random(3);
    load_mems();
    b = int'($urandom_range(0, 4000)) - 2000;
    run_model(b);
    do_run("rand2", b, 3, 1'b1, prev);

    fill_random(20);
    load_mems();
    b = int'($urandom_range(0, 20000)) - 10000;
    bias = 16'(b);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (500) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_idle", 32'(idle), 1);
    check("abort_finish", 32'(finish), 0);
    check("abort_ofm_zero", 32'(ofm == '0), 1);
    check("abort_ifm_rd", 32'(ifm_rd), 0);
    check("abort_kernel_rd", 32'(kernel_rd), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_finish", 32'(finish), 0);
    run_model(b);
    do_run("after_rst", b, 0, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
